// File: rtl/queue_caller_if.sv
// Handshake and status bundle between the queue front panel (master)
// and the ticket dispenser / call sequencer (slave).
interface queue_caller_if;
  logic       take;
  logic       next;
  logic       arrive;
  logic       done;
  logic [3:0] ticket;
  logic [3:0] serve;
  logic       k;
  logic [4:0] waiting;
  logic       full;
  logic       busy;

  modport master (
    output take, next, arrive, done,
    input  ticket, serve, k, waiting, full, busy
  );

  modport slave (
    input  take, next, arrive, done,
    output ticket, serve, k, waiting, full, busy
  );
endinterface

// File: rtl/queue_caller.sv
// Ticket dispenser and call sequencer with bounded no-show timeout.
// Optional QUEUE_AUTO_ADVANCE_EN: a no-show immediately calls the next waiting ticket.
module queue_caller #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input logic          clk,
  input logic          rst,
  queue_caller_if.slave q
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALL  = 2'b01,
    SERVE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   timer, timer_nx;
  logic [3:0]         ticket, serve, ptr;
  logic [4:0]         waiting, waiting_nx;
  logic               k, full, busy;
  logic               issue, call, timeout;

  // Eligibility is judged on the registered (pre-edge) count.
  assign issue = q.take && !full;

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    call     = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (q.next && (waiting != 5'd0)) begin
          state_nx = CALL;
          call     = 1'b1;
          timer_nx = '0;
        end
      end
      CALL: begin
        if (q.arrive) begin
          state_nx = SERVE;
        end else if (timer == TMO_LAST) begin
          timeout  = 1'b1;
          timer_nx = '0;
`ifdef QUEUE_AUTO_ADVANCE_EN
          if (waiting != 5'd0) begin
            state_nx = CALL;
            call     = 1'b1;
          end else begin
            state_nx = IDLE;
          end
`else
          state_nx = IDLE;
`endif
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      SERVE: begin
        if (q.done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign waiting_nx = waiting + {4'd0, issue} - {4'd0, call};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      ticket  <= 4'd0;
      ptr     <= 4'd1;
      serve   <= 4'd0;
      k       <= 1'b0;
      waiting <= 5'd0;
      full    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      k       <= timeout;
      waiting <= waiting_nx;
      full    <= (waiting_nx == 5'd16);
      busy    <= (state_nx != IDLE);
      if (issue) ticket <= ticket + 4'd1;
      if (call) begin
        serve <= ptr;
        ptr   <= ptr + 4'd1;
      end
    end
  end

  assign q.ticket  = ticket;
  assign q.serve   = serve;
  assign q.k       = k;
  assign q.waiting = waiting;
  assign q.full    = full;
  assign q.busy    = busy;

endmodule

// File: tb/tb_queue_caller.sv
// Directed bench for queue_caller: issue, call, no-show, wrap, collisions, async reset.
module tb_queue_caller;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  queue_caller_if qif ();

  queue_caller #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_run++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    qif.take = 1'b0; qif.next = 1'b0; qif.arrive = 1'b0; qif.done = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ticket"},  32'(qif.ticket),  0);
    chk({tag, ".serve"},   32'(qif.serve),   0);
    chk({tag, ".k"},       32'(qif.k),       0);
    chk({tag, ".waiting"}, 32'(qif.waiting), 0);
    chk({tag, ".full"},    32'(qif.full),    0);
    chk({tag, ".busy"},    32'(qif.busy),    0);
  endtask

  task automatic take_n(input int n);
    qif.take = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    qif.take = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    idle_in();
    rst = 1'b1;
    #1;
    chk_reset_vals("por");
    #12;
    rst = 1'b0;
    cyc();
    chk_reset_vals("post_rst");

    // Issue three, call one, serve it.
    take_n(3);
    chk("issue.ticket",  32'(qif.ticket),  3);
    chk("issue.waiting", 32'(qif.waiting), 3);
    qif.next = 1'b1; cyc(); qif.next = 1'b0;
    chk("call.serve",   32'(qif.serve),   1);
    chk("call.waiting", 32'(qif.waiting), 2);
    chk("call.busy",    32'(qif.busy),    1);
    qif.arrive = 1'b1; cyc(); qif.arrive = 1'b0;
    chk("arrive.busy", 32'(qif.busy), 1);
    qif.done = 1'b1; cyc(); qif.done = 1'b0;
    chk("done.busy",  32'(qif.busy),  0);
    chk("done.serve", 32'(qif.serve), 1);

    // No-show: k exactly on the 8th edge after entering CALL.
    do_reset();
    take_n(2);
    qif.next = 1'b1; cyc(); qif.next = 1'b0;
    chk("ns.serve", 32'(qif.serve), 1);
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk($sformatf("ns.k_low%0d", i), 32'(qif.k), 0);
    end
    cyc();
    chk("ns.k_pulse", 32'(qif.k), 1);
`ifdef QUEUE_AUTO_ADVANCE_EN
    chk("ns.serve_adv",   32'(qif.serve),   2);
    chk("ns.busy_adv",    32'(qif.busy),    1);
    chk("ns.waiting_adv", 32'(qif.waiting), 0);
`else
    chk("ns.serve_hold", 32'(qif.serve),   1);
    chk("ns.busy_idle",  32'(qif.busy),    0);
    chk("ns.waiting",    32'(qif.waiting), 1);
`endif
    cyc();
    chk("ns.k_end", 32'(qif.k), 0);

    // arrive on the timeout edge wins.
    do_reset();
    take_n(1);
    qif.next = 1'b1; cyc(); qif.next = 1'b0;
    for (int i = 1; i < 8; i++) cyc();
    chk("arrto.still_call", 32'(qif.busy), 1);
    qif.arrive = 1'b1; cyc(); qif.arrive = 1'b0;
    chk("arrto.k",    32'(qif.k),    0);
    chk("arrto.busy", 32'(qif.busy), 1);
    for (int i = 0; i < 9; i++) cyc();
    chk("arrto.k_never", 32'(qif.k),    0);
    chk("arrto.serving", 32'(qif.busy), 1);
    qif.done = 1'b1; cyc(); qif.done = 1'b0;
    chk("arrto.done", 32'(qif.busy), 0);

    // Full, refusal and wrap.
    do_reset();
    take_n(16);
    chk("full.waiting", 32'(qif.waiting), 16);
    chk("full.full",    32'(qif.full),    1);
    chk("full.ticket",  32'(qif.ticket),  0);
    take_n(1);
    chk("full17.waiting", 32'(qif.waiting), 16);
    chk("full17.ticket",  32'(qif.ticket),  0);
    for (int i = 0; i < 16; i++) begin
      qif.next = 1'b1; cyc(); qif.next = 1'b0;
      chk($sformatf("wrap.serve%0d", i), 32'(qif.serve), (i + 1) % 16);
      if (i == 0) begin
        chk("wrap.full_drop", 32'(qif.full),    0);
        chk("wrap.wait15",    32'(qif.waiting), 15);
      end
      qif.arrive = 1'b1; cyc(); qif.arrive = 1'b0;
      qif.done   = 1'b1; cyc(); qif.done   = 1'b0;
    end
    chk("wrap.empty", 32'(qif.waiting), 0);
    qif.next = 1'b1; cyc(); qif.next = 1'b0;
    chk("wrap.next_empty", 32'(qif.busy), 0);

    // take+next with waiting=2.
    do_reset();
    take_n(2);
    qif.take = 1'b1; qif.next = 1'b1; cyc(); idle_in();
    chk("sim2.waiting", 32'(qif.waiting), 2);
    chk("sim2.ticket",  32'(qif.ticket),  3);
    chk("sim2.serve",   32'(qif.serve),   1);
    chk("sim2.busy",    32'(qif.busy),    1);

    // take+next with waiting=0: the new ticket is not called.
    do_reset();
    qif.take = 1'b1; qif.next = 1'b1; cyc(); idle_in();
    chk("sim0.waiting", 32'(qif.waiting), 1);
    chk("sim0.busy",    32'(qif.busy),    0);
    chk("sim0.serve",   32'(qif.serve),   0);

    // take at full is refused even while a call happens.
    do_reset();
    take_n(16);
    qif.take = 1'b1; qif.next = 1'b1; cyc(); idle_in();
    chk("simfull.waiting", 32'(qif.waiting), 15);
    chk("simfull.ticket",  32'(qif.ticket),  0);
    chk("simfull.full",    32'(qif.full),    0);

    // Asynchronous reset in SERVE with waiting=5.
    do_reset();
    take_n(6);
    qif.next = 1'b1; cyc(); qif.next = 1'b0;
    qif.arrive = 1'b1; cyc(); qif.arrive = 1'b0;
    chk("ar.waiting", 32'(qif.waiting), 5);
    chk("ar.busy",    32'(qif.busy),    1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    #1;
    rst = 1'b0;
    qif.next = 1'b1; cyc(); qif.next = 1'b0;
    chk("ar.no_call", 32'(qif.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
